// File: rtl/operand_fetch_sequencer_pkg.sv
// Shared operand-fetch definitions: source-mux select codes, source encoding
// range bounds and sequencer state encodings.
package operand_fetch_sequencer_pkg;

    // Select codes driven to the source mux
    localparam logic [3:0] SelLiteral = 4'd0;
    localparam logic [3:0] SelConst   = 4'd1;
    localparam logic [3:0] SelVgpr    = 4'd2;
    localparam logic [3:0] SelSgpr    = 4'd3;
    localparam logic [3:0] SelVccLo   = 4'd4;
    localparam logic [3:0] SelVccHi   = 4'd5;
    localparam logic [3:0] SelM0      = 4'd6;
    localparam logic [3:0] SelExecLo  = 4'd7;
    localparam logic [3:0] SelExecHi  = 4'd8;
    localparam logic [3:0] SelVccz    = 4'd9;
    localparam logic [3:0] SelExecz   = 4'd10;
    localparam logic [3:0] SelScc     = 4'd11;

    // Source encoding values and range bounds
    localparam logic [8:0] EncSgprMax   = 9'd103;
    localparam logic [8:0] EncVccLo     = 9'd106;
    localparam logic [8:0] EncVccHi     = 9'd107;
    localparam logic [8:0] EncM0        = 9'd124;
    localparam logic [8:0] EncExecLo    = 9'd126;
    localparam logic [8:0] EncExecHi    = 9'd127;
    localparam logic [8:0] EncPosIntMin = 9'd128;
    localparam logic [8:0] EncPosIntMax = 9'd192;
    localparam logic [8:0] EncNegIntMax = 9'd208;
    localparam logic [8:0] EncVccz      = 9'd251;
    localparam logic [8:0] EncExecz     = 9'd252;
    localparam logic [8:0] EncScc       = 9'd253;
    localparam logic [8:0] EncLiteral   = 9'd255;
    localparam logic [8:0] EncVgprMin   = 9'd256;

    // Sequencer state encodings
    localparam logic [2:0] StIdleEnc    = 3'd0;
    localparam logic [2:0] StSelectEnc  = 3'd1;
    localparam logic [2:0] StWaitEnc    = 3'd2;
    localparam logic [2:0] StCaptureEnc = 3'd3;
    localparam logic [2:0] StDoneEnc    = 3'd4;

    typedef enum logic [2:0] {
        StIdle    = StIdleEnc,
        StSelect  = StSelectEnc,
        StWait    = StWaitEnc,
        StCapture = StCaptureEnc,
        StDone    = StDoneEnc
    } fetch_state_e;

endpackage

// File: rtl/src_encoding_decoder.sv
// Combinational decode of one 9-bit operand encoding into mux select, inline
// constant, register-file flags/addresses and an illegal flag.
module src_encoding_decoder
    import operand_fetch_sequencer_pkg::*;
(
    input  logic [8:0] enc,
    output logic [3:0] select,
    output logic [9:0] constant,
    output logic       is_sgpr,
    output logic [6:0] sgpr_addr,
    output logic       is_vgpr,
    output logic [7:0] vgpr_addr,
    output logic       illegal
);

    always_comb begin
        select    = SelLiteral;
        constant  = '0;
        is_sgpr   = 1'b0;
        is_vgpr   = 1'b0;
        illegal   = 1'b0;
        sgpr_addr = enc[6:0];
        vgpr_addr = enc[7:0];
        if (enc >= EncVgprMin) begin
            select  = SelVgpr;
            is_vgpr = 1'b1;
        end else if (enc <= EncSgprMax) begin
            select  = SelSgpr;
            is_sgpr = 1'b1;
        end else if (enc >= EncPosIntMin && enc <= EncPosIntMax) begin
            select   = SelConst;
            constant = {1'b0, enc} - {1'b0, EncPosIntMin};
        end else if (enc > EncPosIntMax && enc <= EncNegIntMax) begin
            // 193..208 map to -1..-16; the 10-bit subtraction wraps to two's complement
            select   = SelConst;
            constant = {1'b0, EncPosIntMax} - {1'b0, enc};
        end else begin
            case (enc)
                EncVccLo:   select = SelVccLo;
                EncVccHi:   select = SelVccHi;
                EncM0:      select = SelM0;
                EncExecLo:  select = SelExecLo;
                EncExecHi:  select = SelExecHi;
                EncVccz:    select = SelVccz;
                EncExecz:   select = SelExecz;
                EncScc:     select = SelScc;
                EncLiteral: select = SelLiteral;
                default:    illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/operand_fetch_sequencer.sv
// Sequences up to three operand fetches per issued instruction through the
// register files and source mux. Optional macro: OPERAND_FETCH_PERF_EN.
module operand_fetch_sequencer
    import operand_fetch_sequencer_pkg::*;
#(
    parameter int unsigned SGPR_RD_LAT = 1,
    parameter int unsigned VGPR_RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_num_src,
    input  logic [8:0]  issue_src0,
    input  logic [8:0]  issue_src1,
    input  logic [8:0]  issue_src2,
    input  logic        flush,
    output logic [3:0]  source_mux_select,
    output logic [9:0]  src_constant,
    output logic        sgpr_rd_en,
    output logic [6:0]  sgpr_rd_addr,
    output logic        vgpr_rd_en,
    output logic [7:0]  vgpr_rd_addr,
    output logic        operand_capture,
    output logic [1:0]  operand_idx,
    output logic        fetch_done,
    output logic        illegal_src
`ifdef OPERAND_FETCH_PERF_EN
    ,
    output logic [31:0] perf_wait_cycles
`endif
);

    fetch_state_e state_q, state_d;
    logic [1:0]   idx_q, count_q, wait_cnt_q;
    logic [8:0]   src0_q, src1_q, src2_q;
    logic [3:0]   sel_q;
    logic [9:0]   const_q;
    logic         sgpr_q, vgpr_q, illegal_q;
    logic [6:0]   sgpr_addr_q;
    logic [7:0]   vgpr_addr_q;

    logic [8:0]   dec_enc;
    logic [3:0]   dec_select;
    logic [9:0]   dec_constant;
    logic         dec_sgpr, dec_vgpr, dec_illegal;
    logic [6:0]   dec_sgpr_addr;
    logic [7:0]   dec_vgpr_addr;

    logic         accept, more_src, advance, load_sel, needs_wait, wait_last;
    int unsigned  lat_cur;

    assign accept   = (state_q == StIdle) && issue_valid && !flush;
    assign more_src = ({1'b0, idx_q} + 3'd1) < {1'b0, count_q};
    assign advance  = (state_q == StCapture) && more_src && !flush;
    assign load_sel = accept || advance;

    assign lat_cur    = sgpr_q ? SGPR_RD_LAT : VGPR_RD_LAT;
    assign needs_wait = (sgpr_q || vgpr_q) && (lat_cur > 32'd1);
    assign wait_last  = (32'(wait_cnt_q) + 32'd2) >= lat_cur;

    // Decode the operand about to enter SELECT so its select/constant register on entry
    always_comb begin
        dec_enc = issue_src0;
        if (state_q != StIdle) begin
            case (idx_q)
                2'd0:    dec_enc = src1_q;
                2'd1:    dec_enc = src2_q;
                default: dec_enc = src0_q;
            endcase
        end
    end

    src_encoding_decoder u_decoder (
        .enc       (dec_enc),
        .select    (dec_select),
        .constant  (dec_constant),
        .is_sgpr   (dec_sgpr),
        .sgpr_addr (dec_sgpr_addr),
        .is_vgpr   (dec_vgpr),
        .vgpr_addr (dec_vgpr_addr),
        .illegal   (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (issue_valid) state_d = StSelect;
            StSelect: begin
                if (illegal_q)       state_d = StDone;
                else if (needs_wait) state_d = StWait;
                else                 state_d = StCapture;
            end
            StWait:    if (wait_last) state_d = StCapture;
            StCapture: state_d = more_src ? StSelect : StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_comb begin
        issue_ready       = (state_q == StIdle);
        source_mux_select = sel_q;
        src_constant      = const_q;
        sgpr_rd_en        = (state_q == StSelect) && sgpr_q && !flush;
        vgpr_rd_en        = (state_q == StSelect) && vgpr_q && !flush;
        sgpr_rd_addr      = sgpr_addr_q;
        vgpr_rd_addr      = vgpr_addr_q;
        operand_capture   = (state_q == StCapture) && !flush;
        operand_idx       = idx_q;
        fetch_done        = (state_q == StDone) && !flush;
        illegal_src       = (state_q == StDone) && illegal_q && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q       <= '0;
            count_q     <= '0;
            wait_cnt_q  <= '0;
            src0_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            sel_q       <= '0;
            const_q     <= '0;
            sgpr_q      <= 1'b0;
            vgpr_q      <= 1'b0;
            illegal_q   <= 1'b0;
            sgpr_addr_q <= '0;
            vgpr_addr_q <= '0;
        end else begin
            if (accept) begin
                src0_q  <= issue_src0;
                src1_q  <= issue_src1;
                src2_q  <= issue_src2;
                count_q <= (issue_num_src == 2'd0) ? 2'd1 : issue_num_src;
                idx_q   <= '0;
            end else if (advance) begin
                idx_q <= idx_q + 2'd1;
            end
            if (load_sel) begin
                sel_q       <= dec_select;
                const_q     <= dec_constant;
                sgpr_q      <= dec_sgpr;
                vgpr_q      <= dec_vgpr;
                illegal_q   <= dec_illegal;
                sgpr_addr_q <= dec_sgpr_addr;
                vgpr_addr_q <= dec_vgpr_addr;
            end
            wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 2'd1 : 2'd0;
        end
    end

`ifdef OPERAND_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   perf_wait_cycles <= '0;
        else if (state_q == StWait) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Self-checking bench: directed and random instructions compared cycle by
// cycle against a trace model built from the operand decode table and latencies.
module tb_operand_fetch_sequencer;

    localparam int SLAT = 1;
    localparam int VLAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [1:0]  issue_num_src = '0;
    logic [8:0]  issue_src0 = '0, issue_src1 = '0, issue_src2 = '0;
    logic        flush = 1'b0;
    logic [3:0]  source_mux_select;
    logic [9:0]  src_constant;
    logic        sgpr_rd_en, vgpr_rd_en;
    logic [6:0]  sgpr_rd_addr;
    logic [7:0]  vgpr_rd_addr;
    logic        operand_capture, fetch_done, illegal_src;
    logic [1:0]  operand_idx;
`ifdef OPERAND_FETCH_PERF_EN
    logic [31:0] perf_wait_cycles;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    operand_fetch_sequencer #(.SGPR_RD_LAT(SLAT), .VGPR_RD_LAT(VLAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_num_src     (issue_num_src),
        .issue_src0        (issue_src0),
        .issue_src1        (issue_src1),
        .issue_src2        (issue_src2),
        .flush             (flush),
        .source_mux_select (source_mux_select),
        .src_constant      (src_constant),
        .sgpr_rd_en        (sgpr_rd_en),
        .sgpr_rd_addr      (sgpr_rd_addr),
        .vgpr_rd_en        (vgpr_rd_en),
        .vgpr_rd_addr      (vgpr_rd_addr),
        .operand_capture   (operand_capture),
        .operand_idx       (operand_idx),
        .fetch_done        (fetch_done),
        .illegal_src       (illegal_src)
`ifdef OPERAND_FETCH_PERF_EN
        ,
        .perf_wait_cycles  (perf_wait_cycles)
`endif
    );

    // One expected cycle of observable behaviour; chk marks cycles where select/constant matter
    typedef struct packed {
        logic       ready;
        logic       sen;
        logic [6:0] sa;
        logic       ven;
        logic [7:0] va;
        logic       cap;
        logic [1:0] idx;
        logic       done;
        logic       ill;
        logic       chk;
        logic [3:0] sel;
        logic [9:0] cst;
    } exp_t;

    exp_t exp_q[$];
    logic [8:0] specials [9] = '{9'd106, 9'd107, 9'd124, 9'd126, 9'd127,
                                 9'd251, 9'd252, 9'd253, 9'd255};

    // kind: 0 = no register, 1 = sgpr, 2 = vgpr, 3 = illegal
    function automatic void ref_decode(input int e, output int sel, output int cst,
                                       output int kind, output int addr);
        sel = 0; cst = 0; kind = 0; addr = 0;
        if (e <= 103)                 begin sel = 3; kind = 1; addr = e; end
        else if (e == 106)            sel = 4;
        else if (e == 107)            sel = 5;
        else if (e == 124)            sel = 6;
        else if (e == 126)            sel = 7;
        else if (e == 127)            sel = 8;
        else if (e >= 128 && e <= 192) begin sel = 1; cst = e - 128; end
        else if (e >= 193 && e <= 208) begin sel = 1; cst = -(e - 192); end
        else if (e == 251)            sel = 9;
        else if (e == 252)            sel = 10;
        else if (e == 253)            sel = 11;
        else if (e == 255)            sel = 0;
        else if (e >= 256)            begin sel = 2; kind = 2; addr = e - 256; end
        else                          kind = 3;
    endfunction

    task automatic build_trace(input logic [8:0] s0, input logic [8:0] s1,
                               input logic [8:0] s2, input logic [1:0] num);
        logic [8:0] s [3];
        int n, sel, cst, kind, addr, lat;
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2;
        n = (num == 2'd0) ? 1 : int'(num);
        for (int i = 0; i < n; i++) begin
            ref_decode(int'(s[i]), sel, cst, kind, addr);
            e = '0;
            e.chk = (kind != 3);
            e.sel = sel[3:0];
            e.cst = cst[9:0];
            if (kind == 1) begin e.sen = 1'b1; e.sa = addr[6:0]; end
            if (kind == 2) begin e.ven = 1'b1; e.va = addr[7:0]; end
            exp_q.push_back(e);
            if (kind == 3) begin
                e = '0; e.done = 1'b1; e.ill = 1'b1; exp_q.push_back(e);
                e = '0; e.ready = 1'b1; exp_q.push_back(e);
                return;
            end
            lat = (kind == 1) ? SLAT : ((kind == 2) ? VLAT : 1);
            e.sen = 1'b0; e.ven = 1'b0;
            for (int w = 1; w < lat; w++) exp_q.push_back(e);
            e.cap = 1'b1; e.idx = 2'(i);
            exp_q.push_back(e);
        end
        e = '0; e.done = 1'b1; exp_q.push_back(e);
        e = '0; e.ready = 1'b1; exp_q.push_back(e);
    endtask

    // Snapshot of DUT outputs; fields the expectation marks as don't-care are copied over
    function automatic exp_t observe(input exp_t e);
        exp_t o;
        o.ready = issue_ready;
        o.sen   = sgpr_rd_en;
        o.sa    = e.sen ? sgpr_rd_addr : e.sa;
        o.ven   = vgpr_rd_en;
        o.va    = e.ven ? vgpr_rd_addr : e.va;
        o.cap   = operand_capture;
        o.idx   = e.cap ? operand_idx : e.idx;
        o.done  = fetch_done;
        o.ill   = illegal_src;
        o.chk   = e.chk;
        o.sel   = e.chk ? source_mux_select : e.sel;
        o.cst   = e.chk ? src_constant : e.cst;
        return o;
    endfunction

    function automatic logic [8:0] rand_enc();
        case ($urandom_range(0, 5))
            0:       return 9'($urandom_range(0, 103));
            1:       return specials[$urandom_range(0, 8)];
            2:       return 9'($urandom_range(128, 208));
            3:       return 9'($urandom_range(256, 511));
            4:       return 9'($urandom_range(0, 511));
            default: return 9'($urandom_range(128, 192));
        endcase
    endfunction

    task automatic test_reset();
        issue_valid = 1'b1; issue_src0 = 9'd5; issue_num_src = 2'd1;
        repeat (2) @(negedge clk);
        total++;
        if ({source_mux_select, src_constant, sgpr_rd_en, vgpr_rd_en, operand_capture,
             fetch_done, illegal_src, operand_idx} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got sel=%0d cst=%0d en=%b%b cap=%b done=%b ill=%b want 0",
                     source_mux_select, src_constant, sgpr_rd_en, vgpr_rd_en,
                     operand_capture, fetch_done, illegal_src);
        end
        issue_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (issue_ready !== 1'b1 || sgpr_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready=%b sgpr_en=%b want ready=1 sgpr_en=0",
                     issue_ready, sgpr_rd_en);
        end
    endtask

    task automatic test_sequences();
        logic [8:0] s0, s1, s2;
        logic [1:0] n;
        exp_t e, o;
        for (int t = 0; t < 44; t++) begin
            case (t)
                0:       begin s0 = 9'd130; s1 = 9'd0;   s2 = 9'd0;   n = 2'd1; end
                1:       begin s0 = 9'd5;   s1 = 9'd300; s2 = 9'd200; n = 2'd3; end
                2:       begin s0 = 9'd104; s1 = 9'd5;   s2 = 9'd5;   n = 2'd1; end
                3:       begin s0 = 9'd511; s1 = 9'd0;   s2 = 9'd0;   n = 2'd0; end
                default: begin
                    s0 = rand_enc(); s1 = rand_enc(); s2 = rand_enc();
                    n = 2'($urandom_range(0, 3));
                end
            endcase
            exp_q.delete();
            build_trace(s0, s1, s2, n);
            issue_src0 = s0; issue_src1 = s1; issue_src2 = s2; issue_num_src = n;
            issue_valid = 1'b1;
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clk);
                if (k == 0) issue_valid = 1'b0;
                e = exp_q[k];
                o = observe(e);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL seq%0d src={%0d,%0d,%0d} n=%0d cyc%0d got=%h want=%h",
                             t, s0, s1, s2, n, k, o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int l1;
        exp_t e, o;
        exp_q.delete();
        build_trace(9'd255, 9'd253, 9'd0, 2'd2);
        l1 = exp_q.size();
        build_trace(9'd253, 9'd130, 9'd0, 2'd2);
        issue_src0 = 9'd255; issue_src1 = 9'd253; issue_num_src = 2'd2;
        issue_valid = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin issue_src0 = 9'd253; issue_src1 = 9'd130; end
            if (k == l1) issue_valid = 1'b0;
            e = exp_q[k];
            o = observe(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL back_to_back cyc%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_flush();
        // flush with an offered issue in IDLE must not accept it
        issue_src0 = 9'd5; issue_src1 = 9'd300; issue_num_src = 2'd2;
        issue_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; issue_valid = 1'b0;
        total++;
        if (issue_ready !== 1'b1 || sgpr_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL flush_blocks_issue ready=%b sgpr_en=%b want 1/0",
                     issue_ready, sgpr_rd_en);
        end
        issue_valid = 1'b1;
        repeat (3) @(negedge clk);  // SELECT0, CAPTURE0, SELECT1
        issue_valid = 1'b0;
        total++;
        if (vgpr_rd_en !== 1'b1 || vgpr_rd_addr !== 8'd44) begin
            bad++;
            $display("FAIL flush_setup vgpr_en=%b addr=%0d want 1/44", vgpr_rd_en, vgpr_rd_addr);
        end
        @(negedge clk);  // WAIT of operand 1
        flush = 1'b1;
        #1;
        total++;
        if (operand_capture !== 1'b0 || fetch_done !== 1'b0) begin
            bad++;
            $display("FAIL flush_in_wait cap=%b done=%b want 0/0", operand_capture, fetch_done);
        end
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (issue_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_to_idle ready=%b want 1", issue_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (operand_capture !== 1'b0 || fetch_done !== 1'b0) begin
                bad++;
                $display("FAIL flush_no_tail cyc%0d cap=%b done=%b want 0/0",
                         i, operand_capture, fetch_done);
            end
        end
        // flush during SELECT drops the read-enable pulse
        issue_src0 = 9'd7; issue_num_src = 2'd1; issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        flush = 1'b1;
        #1;
        total++;
        if (sgpr_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL flush_drops_rd_en sgpr_en=%b want 0", sgpr_rd_en);
        end
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (issue_ready !== 1'b1 || fetch_done !== 1'b0) begin
                bad++;
                $display("FAIL flush_select_idle cyc%0d ready=%b done=%b want 1/0",
                         i, issue_ready, fetch_done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        issue_src0 = 9'd130; issue_num_src = 2'd1; issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);  // CAPTURE
        total++;
        if (operand_capture !== 1'b1 || source_mux_select !== 4'd1 || src_constant !== 10'd2) begin
            bad++;
            $display("FAIL reset_mid_setup cap=%b sel=%0d cst=%0d want 1/1/2",
                     operand_capture, source_mux_select, src_constant);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({source_mux_select, src_constant, operand_capture, fetch_done, sgpr_rd_en,
             vgpr_rd_en, illegal_src} !== '0 || issue_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_outputs sel=%0d cst=%0d cap=%b done=%b ready=%b want 0s/ready=1",
                     source_mux_select, src_constant, operand_capture, fetch_done, issue_ready);
        end
`ifdef OPERAND_FETCH_PERF_EN
        total++;
        if (perf_wait_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf got=%0d want 0", perf_wait_cycles);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (issue_ready !== 1'b1 || fetch_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_idle cyc%0d ready=%b done=%b want 1/0",
                         i, issue_ready, fetch_done);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequences();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch_sequencer.md
OPERAND_FETCH_SEQUENCER -- requirements
Module: operand_fetch_sequencer

Interface
REQ-001 SHALL have parameter SGPR_RD_LAT, default 1, meaning cycles from sgpr_rd_en to valid sgpr data (range 1-3).
REQ-002 SHALL have parameter VGPR_RD_LAT, default 2, meaning cycles from vgpr_rd_en to valid vgpr data (range 1-3).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port issue_valid  input  1  instruction offered.
REQ-006 SHALL have port issue_ready  output  1  high only in IDLE.
REQ-007 SHALL have port issue_num_src  input  2  operand count, 1-3; 0 treated as 1.
REQ-008 SHALL have port issue_src0/issue_src1/issue_src2  input  9 each  operand encodings.
REQ-009 SHALL have port flush  input  1  abort current sequence.
REQ-010 SHALL have port source_mux_select  output  4  select code driven to the source mux.
REQ-011 SHALL have port src_constant  output  10  signed inline constant.
REQ-012 SHALL have ports sgpr_rd_en (output, 1) and sgpr_rd_addr (output, 7); vgpr_rd_en (output, 1) and vgpr_rd_addr (output, 8).
REQ-013 SHALL have ports operand_capture (output, 1), operand_idx (output, 2), fetch_done (output, 1) and illegal_src (output, 1).

Function
REQ-014 SHALL implement the states IDLE, SELECT, WAIT, CAPTURE, DONE.
REQ-015 IDLE: issue_valid&issue_ready SHALL latch the sources and count, clear the index, and go to SELECT.
REQ-016 SELECT SHALL decode src[idx] and pulse sgpr_rd_en or vgpr_rd_en for exactly one cycle when applicable, then go to WAIT if the operand is register-sourced, else CAPTURE.
REQ-017 WAIT SHALL count to the matching latency minus 1 (0 cycles when the latency is 1), then go to CAPTURE.
REQ-018 CAPTURE SHALL pulse operand_capture with operand_idx=idx; then idx+1<count goes to SELECT, else DONE.
REQ-019 DONE SHALL pulse fetch_done for one cycle, then go to IDLE.
REQ-020 source_mux_select and src_constant SHALL be registered at SELECT entry and held stable through CAPTURE.
REQ-021 Decode (encoding -> select): 0-103 -> 3 with sgpr_rd_addr=enc[6:0].
REQ-022 Decode: 106 -> 4; 107 -> 5; 124 -> 6; 126 -> 7; 127 -> 8.
REQ-023 Decode: 128-192 -> 1 with src_constant=enc-128; 193-208 -> 1 with src_constant=-(enc-192), sign-extended to 10 bits.
REQ-024 Decode: 251 -> 9; 252 -> 10; 253 -> 11; 255 -> 0 (literal).
REQ-025 Decode: 256-511 -> 2 with vgpr_rd_addr=enc[7:0].
REQ-026 Any other encoding SHALL pulse illegal_src and fetch_done in the next cycle, skip the remaining operands, and return to IDLE.
REQ-027 flush SHALL force IDLE on the next edge from any state, drop the rd_en/capture pulses, and suppress fetch_done; flush has priority over every transition.
REQ-028 flush together with issue_valid in IDLE SHALL not accept the issue.
REQ-029 Latency per operand: non-register = 2 cycles (SELECT, CAPTURE); register = 2+LAT-1 cycles.

Reset
REQ-030 On rst low, the state SHALL be IDLE, idx=0, and source_mux_select=0, src_constant=0, all enables/pulses=0, issue_ready=1 one cycle after release.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence without asserting fetch_done.

Configuration
REQ-032 Macro OPERAND_FETCH_PERF_EN defined SHALL add output perf_wait_cycles [31:0], counting cycles spent in WAIT, wrapping at 2^32, cleared by reset.
REQ-033 Without OPERAND_FETCH_PERF_EN, the port and the counter SHALL be absent, with behaviour otherwise identical.

Structure
REQ-034 The select codes 0-11, the state encodings and the encoding range bounds SHALL be localparams in the shared operand-fetch definitions package/include.
REQ-035 The decode of one encoding SHALL be a combinational sub-module src_encoding_decoder (outputs: select, const, sgpr/vgpr flag and address, illegal).

Verification
REQ-036 Single source 130 -> select=1, src_constant=2, capture at cycle 2, fetch_done at cycle 3, no rd_en.
REQ-037 Three sources {5, 300, 200}, VGPR_RD_LAT=2 -> sgpr_rd_addr=5, then vgpr_rd_addr=44, then src_constant=-8; three captures idx 0,1,2; one fetch_done.
REQ-038 Source 104 -> illegal_src=1, fetch_done=1, no capture, issue_ready=1 next cycle.
REQ-039 flush asserted during WAIT of operand 1 -> IDLE next cycle, no further capture, no fetch_done.
REQ-040 rst pulsed low during CAPTURE -> outputs zero immediately, IDLE after release; with OPERAND_FETCH_PERF_EN, perf_wait_cycles=0.
REQ-041 Sources {255, 253}, back-to-back issue -> selects 0 then 11; the second instruction is accepted only after DONE.
